// File: rtl/accelkan_pkg.sv
// Shared types and default widths for the layer sequencer and buffer.
// State encoding is fixed; other blocks decode it.
package accelkan_pkg;

    localparam int LW_DEF = 4;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

endpackage

// File: rtl/layer_sequencer_if.sv
// Control and stream-monitor bundle of the layer sequencer.
// The sequencer is the slave side; the controller/bench is the master.
interface layer_sequencer_if
    import accelkan_pkg::*;
#(
    parameter int LW = LW_DEF,
    parameter int CW = CW_DEF
) ();

    logic          start;
    logic [LW-1:0] cfg_nlayers;
    logic [CW-1:0] cfg_olen;
    logic          s_axis0_tvalid;
    logic          s_axis0_tready;
    logic          s_axis0_tlast;
    logic          k_done;
    logic          s_axis1_tvalid;
    logic          s_axis1_tready;
    logic          s_axis1_tlast;
    logic          c_new;
    logic          c_lfirst;
    logic          c_llast;
    logic [LW-1:0] layer_idx;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, cfg_nlayers, cfg_olen,
        input  s_axis0_tvalid, s_axis0_tready, s_axis0_tlast,
        input  k_done, s_axis1_tvalid, s_axis1_tready,
        output s_axis1_tlast, c_new, c_lfirst, c_llast,
        output layer_idx, busy, done, err
    );

    modport master (
        output start, cfg_nlayers, cfg_olen,
        output s_axis0_tvalid, s_axis0_tready, s_axis0_tlast,
        output k_done, s_axis1_tvalid, s_axis1_tready,
        input  s_axis1_tlast, c_new, c_lfirst, c_llast,
        input  layer_idx, busy, done, err
    );

endinterface

// File: rtl/layer_sequencer_beat_counter.sv
// Saturating beat counter with clear, enable and terminal-beat decode.
// last_o flags the final beat of a term_i-long burst (never for term_i=0).
module beat_counter
    import accelkan_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] term_i,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;

    assign last_o = (term_i != '0) && (cnt_q == term_i - CW'(1));

    // Count beats, holding at the terminal beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i && !last_o)
            cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequencer that walks the ping-pong buffer through load, N layers and drain.
// A kernel completion during load is remembered and taken on the last input beat.
module layer_sequencer
    import accelkan_pkg::*;
#(
    parameter int LW = LW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic             aclk,
    input  logic             aresetn,
    layer_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_LOAD    = LOAD;
    localparam logic [1:0] ST_COMPUTE = COMPUTE;
    localparam logic [1:0] ST_DRAIN   = DRAIN;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] nl_q, nl_d;
    logic [CW-1:0] olen_q, olen_d;
    logic [LW-1:0] layer_q, layer_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d;
    logic          cnew_q, cnew_d;
    logic          lfirst_q, lfirst_d;
    logic          llast_q, llast_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic in_last, out_hs, in_load, in_idle, in_drain, in_comp;
    logic adv, more, err_set, acc_start, bclr, beat_last, tlast;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_load  = (state_q == ST_LOAD);
    assign in_comp  = (state_q == ST_COMPUTE);
    assign in_drain = (state_q == ST_DRAIN);

    assign in_last = bus.s_axis0_tvalid & bus.s_axis0_tready
                   & bus.s_axis0_tlast;
    assign out_hs  = bus.s_axis1_tvalid & bus.s_axis1_tready;

    assign acc_start = in_idle & bus.start;
    assign more      = layer_q < (nl_q - LW'(1));
    assign adv       = (in_comp & bus.k_done)
                     | (in_load & in_last & (bus.k_done | pend_q));
    assign err_set   = (bus.k_done & (in_idle | in_drain))
                     | (bus.k_done & in_load & pend_q)
                     | (in_last & ~in_load);

    beat_counter #(.CW(CW)) u_beats (
        .clk    (aclk),
        .rst    (aresetn),
        .clr_i  (bclr),
        .en_i   (out_hs & in_drain),
        .term_i (olen_q),
        .last_o (beat_last)
    );

    assign tlast = in_drain & beat_last;

    assign bus.s_axis1_tlast = tlast;
    assign bus.c_new         = cnew_q;
    assign bus.c_lfirst      = lfirst_q;
    assign bus.c_llast       = llast_q;
    assign bus.layer_idx     = layer_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

    // Next-state, strobe and error decode.
    always_comb begin
        state_d  = state_q;
        nl_d     = nl_q;
        olen_d   = olen_q;
        layer_d  = layer_q;
        pend_d   = pend_q;
        cnew_d   = 1'b0;
        lfirst_d = 1'b0;
        llast_d  = 1'b0;
        done_d   = 1'b0;
        bclr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    nl_d   = bus.cfg_nlayers;
                    olen_d = bus.cfg_olen;
                    if (bus.cfg_nlayers != '0) begin
                        state_d  = ST_LOAD;
                        cnew_d   = 1'b1;
                        lfirst_d = 1'b1;
                        layer_d  = '0;
                        pend_d   = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.k_done)
                    pend_d = 1'b1;
                if (in_last) begin
                    state_d = ST_COMPUTE;
                    pend_d  = 1'b0;
                end
            end
            ST_COMPUTE: begin
                pend_d = 1'b0;
            end
            ST_DRAIN: begin
                if (olen_q == '0 || (out_hs && tlast)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
            cnew_d = 1'b1;
            if (more) begin
                layer_d = layer_q + LW'(1);
                state_d = ST_COMPUTE;
            end else begin
                llast_d = 1'b1;
                bclr    = 1'b1;
                state_d = ST_DRAIN;
            end
        end
        err_d  = (acc_start ? 1'b0 : err_q) | err_set;
        busy_d = (state_d != ST_IDLE);
    end

    // State, config latches and registered outputs.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_q  <= ST_IDLE;
            nl_q     <= '0;
            olen_q   <= '0;
            layer_q  <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            cnew_q   <= 1'b0;
            lfirst_q <= 1'b0;
            llast_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nl_q     <= nl_d;
            olen_q   <= olen_d;
            layer_q  <= layer_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            cnew_q   <= cnew_d;
            lfirst_q <= lfirst_d;
            llast_q  <= llast_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed corner sequences, a pass table
// and randomized passes checked against an event-level model.
module tb_layer_sequencer;
    import accelkan_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;

    always #5 aclk = ~aclk;

    layer_sequencer_if bus ();

    layer_sequencer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Event monitor used by the pass runner.
    bit         mon_en = 1'b0;
    bit         prev_tl = 1'b0;
    int         done_cnt, tl_cnt, tl_at, hs_cnt, both_cnt;
    logic [5:0] cq[$];

    always @(negedge aclk) begin
        if (mon_en) begin
            if (prev_tl)
                check("done_after_tlast", 32'(bus.done), 1);
            prev_tl = bus.s_axis1_tvalid & bus.s_axis1_tready
                    & bus.s_axis1_tlast;
            if (bus.c_new)
                cq.push_back({bus.c_lfirst, bus.c_llast, bus.layer_idx});
            if (bus.c_lfirst && bus.c_llast)
                both_cnt++;
            if (bus.done)
                done_cnt++;
            if (bus.s_axis1_tvalid && bus.s_axis1_tready) begin
                hs_cnt++;
                if (bus.s_axis1_tlast) begin
                    tl_cnt++;
                    tl_at = hs_cnt;
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_in();
        bus.s_axis0_tvalid = 1'b0;
        bus.s_axis0_tready = 1'b0;
        bus.s_axis0_tlast  = 1'b0;
        bus.k_done         = 1'b0;
        bus.s_axis1_tvalid = 1'b0;
        bus.s_axis1_tready = 1'b0;
    endtask

    task automatic pulse_start(input int n, input int olen);
        tick();
        bus.start       = 1'b1;
        bus.cfg_nlayers = 4'(n);
        bus.cfg_olen    = 16'(olen);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic in_beat(input bit last, input bit kd);
        tick();
        bus.s_axis0_tvalid = 1'b1;
        bus.s_axis0_tready = 1'b1;
        bus.s_axis0_tlast  = last;
        bus.k_done         = kd;
        tick();
        clear_in();
    endtask

    task automatic kdone();
        tick();
        bus.k_done = 1'b1;
        tick();
        bus.k_done = 1'b0;
    endtask

    task automatic out_beat();
        tick();
        bus.s_axis1_tvalid = 1'b1;
        bus.s_axis1_tready = 1'b1;
        tick();
        clear_in();
    endtask

    // One full pass with random stalls; checks against the event model:
    // c_new list is (first,L0), (L1)..(Ln-1), (last,Ln-1).
    task automatic run_pass(input int n, input int olen, input bit ovl,
                            input int exp_cnew, input int exp_tl,
                            input string tag);
        int nb, kb, rem, cyc;
        bit fin;
        logic [5:0] ev[$];
        cq.delete();
        done_cnt = 0; tl_cnt = 0; tl_at = 0; hs_cnt = 0; both_cnt = 0;
        prev_tl = 1'b0;
        mon_en = 1'b1;
        pulse_start(n, olen);
        if (n != 0) begin
            nb = $urandom_range(6, 1);
            kb = $urandom_range(nb - 1, 0);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(2, 0)) begin
                    tick();
                    bus.s_axis0_tvalid = 1'($urandom % 2);
                    bus.s_axis0_tready = bus.s_axis0_tvalid ? 1'b0
                                       : 1'($urandom % 2);
                    bus.s_axis0_tlast  = 1'b0;
                    bus.k_done         = 1'b0;
                end
                tick();
                bus.s_axis0_tvalid = 1'b1;
                bus.s_axis0_tready = 1'b1;
                bus.s_axis0_tlast  = (b == nb - 1);
                bus.k_done         = ovl && (b == kb);
            end
            tick();
            clear_in();
            rem = ovl ? n - 1 : n;
            for (int k = 0; k < rem; k++) begin
                repeat ($urandom_range(3, 0)) tick();
                kdone();
            end
            if (olen != 0) begin
                fin = 1'b0;
                cyc = 0;
                while (!fin && cyc < 200) begin
                    tick();
                    bus.s_axis1_tvalid = ($urandom % 4) != 0;
                    bus.s_axis1_tready = ($urandom % 4) != 0;
                    @(negedge aclk);
                    if (bus.s_axis1_tvalid && bus.s_axis1_tready
                        && bus.s_axis1_tlast)
                        fin = 1'b1;
                    cyc++;
                end
                tick();
                clear_in();
                check({tag, "_drain_bound"}, 32'(fin), 1);
            end
        end
        repeat (4) tick();
        mon_en = 1'b0;
        if (n != 0) begin
            ev.push_back(6'b10_0000);
            for (int i = 1; i < n; i++)
                ev.push_back({2'b00, 4'(i)});
            ev.push_back({2'b01, 4'(n - 1)});
        end
        check({tag, "_cnew_cnt"}, cq.size(), exp_cnew);
        for (int i = 0; i < cq.size() && i < ev.size(); i++)
            check({tag, "_cnew_ev"}, 32'(cq[i]), 32'(ev[i]));
        check({tag, "_tlast_cnt"}, tl_cnt, exp_tl);
        check({tag, "_tlast_beat"}, tl_at, exp_tl != 0 ? olen : 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_both_flags"}, both_cnt, 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    typedef struct {
        int    n;
        int    olen;
        bit    ovl;
        int    exp_cnew;
        int    exp_tl;
        string name;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, olen;
        bit ovl;
        tbl[0] = '{3, 4, 1'b0, 4, 1, "basic"};
        tbl[1] = '{3, 4, 1'b1, 4, 1, "overlap"};
        tbl[2] = '{1, 2, 1'b0, 2, 1, "single"};
        tbl[3] = '{1, 0, 1'b1, 2, 0, "single_ovl_olen0"};
        tbl[4] = '{0, 3, 1'b0, 0, 0, "nlayers0"};
        tbl[5] = '{4, 0, 1'b0, 5, 0, "olen0"};

        bus.start = 1'b0;
        bus.cfg_nlayers = '0;
        bus.cfg_olen = '0;
        clear_in();

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_c_new", 32'(bus.c_new), 0);
        check("rst_c_lfirst", 32'(bus.c_lfirst), 0);
        check("rst_c_llast", 32'(bus.c_llast), 0);
        check("rst_layer", 32'(bus.layer_idx), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_tlast", 32'(bus.s_axis1_tlast), 0);
        tick();
        aresetn = 1'b0;

        // zero layers: done next cycle, no c_new
        pulse_start(0, 5);
        check("nl0_done", 32'(bus.done), 1);
        check("nl0_cnew", 32'(bus.c_new), 0);
        check("nl0_busy", 32'(bus.busy), 0);
        tick();
        check("nl0_done_pulse", 32'(bus.done), 0);

        // protocol errors, FSM keeps running
        kdone();
        check("err_kd_idle", 32'(bus.err), 1);
        check("err_idle_busy", 32'(bus.busy), 0);
        pulse_start(2, 1);
        check("err_clr_start", 32'(bus.err), 0);
        check("start_cnew", {bus.c_new, bus.c_lfirst, bus.busy}, 3'b111);
        in_beat(1'b1, 1'b0);
        check("load_exit_nocnew", 32'(bus.c_new), 0);
        in_beat(1'b1, 1'b0);
        check("err_stray_last", 32'(bus.err), 1);
        check("stray_no_adv", {bus.c_new, bus.layer_idx}, 0);
        kdone();
        check("cmp_adv1", {bus.c_new, bus.c_llast, bus.layer_idx}, 6'b10_0001);
        kdone();
        check("cmp_last", {bus.c_new, bus.c_llast, bus.layer_idx}, 6'b11_0001);
        check("drain_tlast1", 32'(bus.s_axis1_tlast), 1);
        out_beat();
        check("drain_done", {bus.done, bus.busy, bus.err}, 3'b101);
        check("idle_tlast0", 32'(bus.s_axis1_tlast), 0);
        pulse_start(0, 0);
        check("err_clr_nl0", {bus.err, bus.done}, 2'b01);
        tick();

        // overlap: pending advance taken with the last input beat
        pulse_start(3, 1);
        in_beat(1'b0, 1'b1);
        check("ovl_pending", {bus.c_new, bus.err}, 2'b00);
        in_beat(1'b1, 1'b0);
        check("ovl_adv", {bus.c_new, bus.layer_idx, bus.err}, 6'b1_0001_0);
        kdone();
        check("ovl_l2", {bus.c_new, bus.c_llast, bus.layer_idx}, 6'b10_0010);
        kdone();
        check("ovl_last", {bus.c_new, bus.c_llast, bus.layer_idx}, 6'b11_0010);
        out_beat();
        check("ovl_done", {bus.done, bus.busy}, 2'b10);
        tick();

        // reset in the middle of draining
        pulse_start(1, 4);
        in_beat(1'b1, 1'b0);
        kdone();
        out_beat();
        out_beat();
        check("mid_drain", {bus.busy, bus.s_axis1_tlast}, 2'b10);
        @(posedge aclk);
        #3;
        aresetn = 1'b1;
        #1;
        check("rst_mid_outputs",
              {bus.c_new, bus.c_lfirst, bus.c_llast, bus.layer_idx,
               bus.busy, bus.done, bus.err, bus.s_axis1_tlast}, 0);
        tick();
        aresetn = 1'b0;
        run_pass(2, 3, 1'b0, 3, 1, "after_rst");

        for (int i = 0; i < 6; i++)
            run_pass(tbl[i].n, tbl[i].olen, tbl[i].ovl,
                     tbl[i].exp_cnew, tbl[i].exp_tl, tbl[i].name);

        for (int r = 0; r < 25; r++) begin
            n    = $urandom_range(6, 0);
            olen = $urandom_range(5, 0);
            ovl  = (n != 0) && ($urandom % 2 == 1);
            run_pass(n, olen, ovl, n == 0 ? 0 : n + 1,
                     (n != 0 && olen != 0) ? 1 : 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Control-plane sequencer for the ping-pong layer `buffer`. It generates the `c_new`/`c_lfirst`/`c_llast` strobes that advance the buffer through one input-load phase, N kernel layers and one output-drain phase. It monitors the input AXI-Stream handshake, the kernel's per-layer completion pulse and the output AXI-Stream handshake. It also generates `s_axis1_tlast`, which the buffer does not produce itself.

## Interface
Parameters:
- `LW`, 4 — width of the layer count/index.
- `CW`, 16 — width of the output beat count.

Ports:
- `aclk` in 1 — single clock; all logic on rising edge.
- `aresetn` in 1 — **asynchronous, active-high** reset (asserted = 1), per codebase naming.
- `start` in 1 — one-cycle request to run a network pass; sampled only in IDLE.
- `cfg_nlayers` in LW — compute layers in this pass; latched on accepted `start`.
- `cfg_olen` in CW — output beats in the final vector; latched on accepted `start`.
- `s_axis0_tvalid`, `s_axis0_tready`, `s_axis0_tlast` in 1 each — input stream monitor (observe only).
- `k_done` in 1 — one-cycle pulse: kernel finished the current layer.
- `s_axis1_tvalid`, `s_axis1_tready` in 1 each — output stream monitor.
- `s_axis1_tlast` out 1 — last output beat marker.
- `c_new`, `c_lfirst`, `c_llast` out 1 each — buffer control strobes.
- `layer_idx` out LW — index of the layer currently executing (0-based).
- `busy` out 1 — high in any state other than IDLE.
- `done` out 1 — one-cycle pulse at pass completion.
- `err` out 1 — sticky protocol-error flag; cleared only by an accepted `start` or by reset.

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN.
- **IDLE**
  - `start` with latched `cfg_nlayers` ≠ 0: pulse `c_new` with `c_lfirst`=1, clear `layer_idx`, go to LOAD.
  - `start` with `cfg_nlayers` = 0: pulse `done`, no `c_new`, stay in IDLE.
- **LOAD**
  - Input last beat (`tvalid & tready & tlast`) goes to COMPUTE.
  - `k_done` in LOAD sets a pending flag, because layer 0 may overlap the load. This includes `k_done` on the same cycle as the last input beat.
  - On entry to COMPUTE with pending set, the advance is taken on the entry cycle and pending clears.
- **COMPUTE** (on `k_done` or pending):
  - If `layer_idx` < `cfg_nlayers`−1: pulse `c_new` (`c_lfirst`=`c_llast`=0), increment `layer_idx`, stay in COMPUTE.
  - Otherwise: pulse `c_new` with `c_llast`=1, clear the beat counter, go to DRAIN.
- **DRAIN**
  - Each output handshake (`s_axis1_tvalid & s_axis1_tready`) increments the beat counter.
  - `s_axis1_tlast` = (state==DRAIN) & (count == `cfg_olen`−1).
  - A handshake carrying tlast goes to IDLE and pulses `done`.
  - `cfg_olen` = 0: go to IDLE with `done` on the cycle after entry; `tlast` never asserts.
- `c_lfirst`/`c_llast` are nonzero only while `c_new`=1; they are never both 1.
- `err` sets on any of:
  - `k_done` in IDLE or DRAIN.
  - A second `k_done` while pending is already set.
  - An input last beat outside LOAD.
- `start` outside IDLE is ignored and does not set `err`.
- Counters do not wrap. `layer_idx` saturates at `cfg_nlayers`−1, and the beat counter stops at the terminal beat.

## Timing
- All outputs registered except `s_axis1_tlast`, which is a combinational decode of registers only (no input-to-output path).
- Reset values: every output 0, state IDLE, pending 0, counters 0.
- Accepted `start` at edge t: `c_new`/`c_lfirst` high in cycle t+1, `busy` high from t+1.
- `k_done` at edge t in COMPUTE: `c_new` at t+1, `layer_idx` updated at t+1.
- Input last beat at edge t with pending: state COMPUTE and `c_new` both at t+1.
- Final output handshake at edge t: `done` high at t+1, `busy` low at t+1.
- Reset asserted mid-pass: immediate return to IDLE with all outputs 0, any strobe in flight dropped; the next pass requires a new `start`.

## Structure
- Shared package `accelkan_pkg` holds:
  - the state enum (IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3);
  - default `LW`/`CW` constants, shared with `buffer`.
- One sub-module `beat_counter`:
  - CW-wide, with clear, enable and terminal-count compare;
  - drives the `tlast` decode;
  - reusable elsewhere in the codebase.
- FSM and layer counter stay in `layer_sequencer`.

## Test plan
- **Basic pass:** `cfg_nlayers`=3, `cfg_olen`=4, `start`; 8 input beats with tlast; `k_done` ×3.
  - Expect `c_new` ×4, flags (first), (0,0), (0,0), (last).
  - `layer_idx` 0→1→2.
  - 4 output beats, tlast on beat 4, `done` one cycle after.
- **Overlap:** `k_done` during LOAD, before the input last beat → advance to layer 1 on the COMPUTE-entry cycle; `err`=0.
- **Single layer:** `cfg_nlayers`=1 → `c_new`+`c_lfirst`, then after `k_done` `c_new`+`c_llast`; `c_lfirst` and `c_llast` never coincide.
- **Degenerate config:**
  - `cfg_nlayers`=0 → `done` at t+1, no `c_new`.
  - `cfg_olen`=0 → DRAIN exits with no `tlast`.
- **Protocol errors:** `k_done` in IDLE and a stray input last beat in COMPUTE → `err`=1, held until the next `start`; FSM unaffected.
- **Reset mid-DRAIN:** raise `aresetn` after 2 of 4 beats → all outputs 0 immediately; new `start` runs a clean pass.
